// File: rtl/lstm_gate_tdm.sv
// Time-multiplexed LSTM gate: NUM_PE MAC lanes sweep OUT_SIZE neurons in batches.
// Optional GATE_HARDACT_EN macro applies hard sigmoid/tanh to each written result.
module lstm_gate_tdm #(
    parameter int    DATA_W   = 16,
    parameter int    FRAC_W   = 12,
    parameter int    IN_SIZE  = 31,
    parameter int    OUT_SIZE = 15,
    parameter int    NUM_PE   = 2,
    parameter string ACT      = "sigmoid"
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [DATA_W*IN_SIZE-1:0]             hid,
    input  logic [DATA_W*IN_SIZE*OUT_SIZE-1:0]    rew,
    input  logic [DATA_W*OUT_SIZE-1:0]            bias,
    output logic [(2*DATA_W+1)*OUT_SIZE-1:0]      gate_out,
    output logic                                  busy,
    output logic                                  done
);

    localparam int OUT_W     = 2*DATA_W + 1;
    localparam int PW        = 2*DATA_W;
    localparam int NUM_BATCH = (OUT_SIZE + NUM_PE - 1) / NUM_PE;
    localparam int ACC_W     = 2*DATA_W + $clog2(IN_SIZE+1) + 1;
    localparam int BW        = (NUM_BATCH > 1) ? $clog2(NUM_BATCH) : 1;
    localparam int IW        = $clog2(IN_SIZE+1);

    localparam logic [BW-1:0] LAST_B = BW'(NUM_BATCH-1);
    localparam logic [IW-1:0] LAST_I = IW'(IN_SIZE-1);

    localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    if (ACT != "sigmoid" && ACT != "tanh") begin : g_act_check
        $error("lstm_gate_tdm: ACT must be \"sigmoid\" or \"tanh\"");
    end

    typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, DONE} state_t;

    state_t                   state, state_nx;
    logic [BW-1:0]            b;
    logic [IW-1:0]            i;
    logic signed [ACC_W-1:0]  acc      [NUM_PE];
    logic signed [ACC_W-1:0]  acc_init [NUM_PE];
    logic signed [PW-1:0]     prod     [NUM_PE];
    logic signed [DATA_W-1:0] w_sel    [NUM_PE];
    logic signed [DATA_W-1:0] b_sel    [NUM_PE];
    logic signed [DATA_W-1:0] h_sel;
    int                       nv       [NUM_PE];
    int                       ic;

`ifdef GATE_HARDACT_EN
    localparam bit ACT_SIG = (ACT == "sigmoid");
    localparam logic signed [OUT_W-1:0] ONE  = OUT_W'(2**FRAC_W);
    localparam logic signed [OUT_W-1:0] HALF = OUT_W'(2**(FRAC_W-1));

    function automatic logic signed [OUT_W-1:0] hard_act(
        input logic signed [OUT_W-1:0] v
    );
        logic signed [OUT_W-1:0] s;
        logic signed [OUT_W-1:0] t;
        s = v >>> FRAC_W;
        if (ACT_SIG) begin
            t = (s >>> 2) + HALF;
            if (t < 0) t = '0;
            else if (t > ONE) t = ONE;
        end else begin
            t = s;
            if (t > ONE) t = ONE;
            else if (t < -ONE) t = -ONE;
        end
        return t;
    endfunction
`endif

    function automatic logic [OUT_W-1:0] convert(
        input logic signed [ACC_W-1:0] a
    );
        logic signed [OUT_W-1:0] r;
        if (a[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){a[ACC_W-1]}})
            r = a[ACC_W-1] ? SAT_MIN : SAT_MAX;
        else
            r = a[OUT_W-1:0];
`ifdef GATE_HARDACT_EN
        r = hard_act(r);
`endif
        return r;
    endfunction

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    state_nx = MAC;
            MAC:     if (i == LAST_I) state_nx = WRITE;
            WRITE:   state_nx = (b == LAST_B) ? DONE : LOAD;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    // Per-lane operand selection; out-of-range lanes read neuron 0 harmlessly
    always_comb begin
        ic    = (int'(i) < IN_SIZE) ? int'(i) : 0;
        h_sel = hid[DATA_W*ic +: DATA_W];
        for (int p = 0; p < NUM_PE; p++) begin
            nv[p] = int'(b) * NUM_PE + p;
            if (nv[p] >= OUT_SIZE) nv[p] = 0;
            w_sel[p]    = rew[DATA_W*(IN_SIZE*nv[p] + ic) +: DATA_W];
            b_sel[p]    = bias[DATA_W*nv[p] +: DATA_W];
            prod[p]     = PW'(h_sel) * PW'(w_sel[p]);
            acc_init[p] = ACC_W'(b_sel[p]) <<< FRAC_W;
        end
    end

    // Batch/element counters and lane accumulators
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b <= '0;
            i <= '0;
            for (int p = 0; p < NUM_PE; p++) acc[p] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    b <= '0;
                    i <= '0;
                end
                LOAD: begin
                    i <= '0;
                    for (int p = 0; p < NUM_PE; p++)
                        acc[p] <= acc_init[p];
                end
                MAC: begin
                    i <= i + 1'b1;
                    for (int p = 0; p < NUM_PE; p++)
                        acc[p] <= acc[p] + ACC_W'(prod[p]);
                end
                WRITE: if (b != LAST_B) b <= b + 1'b1;
                default: ;
            endcase
            if (abort) begin
                b <= '0;
                i <= '0;
            end
        end
    end

    // Result write-back: each slot owned by exactly one (batch, lane) pair
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gate_out <= '0;
        end else if (state == WRITE && !abort) begin
            for (int s = 0; s < OUT_SIZE; s++)
                if (b == BW'(s / NUM_PE))
                    gate_out[OUT_W*s +: OUT_W] <= convert(acc[s % NUM_PE]);
        end
    end

endmodule

// File: tb/tb_lstm_gate_tdm.sv
// Self-checking bench for lstm_gate_tdm: vector table plus abort,
// restart, partial-batch and asynchronous-reset sequences.
module tb_lstm_gate_tdm;

    localparam int DW = 16;
    localparam int IN = 31;
    localparam int OS = 15;
    localparam int O5 = 5;
    localparam int OW = 33;

    logic clk;
    logic rst;
    logic start, abort, start5, abort5;
    logic [DW*IN-1:0]    hid;
    logic [DW*IN*OS-1:0] rew;
    logic [DW*OS-1:0]    bias;
    logic [OW*OS-1:0]    gate_out;
    logic busy, done;
    logic [DW*IN*O5-1:0] rew5;
    logic [DW*O5-1:0]    bias5;
    logic [OW*O5-1:0]    gate5;
    logic busy5, done5;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] hv;
        logic [15:0] w_lo;
        logic [15:0] w_hi;
        bit          ramp;
        longint      e_lo;
        longint      e_hi;
    } vec_t;

    vec_t vt [5];

    lstm_gate_tdm dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .hid(hid), .rew(rew), .bias(bias),
        .gate_out(gate_out), .busy(busy), .done(done)
    );

    lstm_gate_tdm #(.OUT_SIZE(O5), .NUM_PE(2)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .abort(abort5),
        .hid(hid), .rew(rew5), .bias(bias5),
        .gate_out(gate5), .busy(busy5), .done(done5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic signed [63:0] got,
                       input logic signed [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic logic signed [63:0] slot(input int n);
        logic signed [OW-1:0] t;
        t = gate_out[OW*n +: OW];
        return 64'(t);
    endfunction

    function automatic logic signed [63:0] slot5(input int n);
        logic signed [OW-1:0] t;
        t = gate5[OW*n +: OW];
        return 64'(t);
    endfunction

    function automatic longint model_act(input longint e);
`ifdef GATE_HARDACT_EN
        longint t;
        t = (e >>> 14) + 2048;
        if (t < 0) t = 0;
        if (t > 4096) t = 4096;
        return t;
`else
        return e;
`endif
    endfunction

    function automatic longint exp_slot(input int v, input int n);
        longint e;
        e = (n < 8) ? vt[v].e_lo : vt[v].e_hi;
        if (vt[v].ramp) e += longint'(n) * 64'sd1048576;
        return model_act(e);
    endfunction

    task automatic set_main(input int v);
        for (int k = 0; k < IN; k++) hid[DW*k +: DW] = vt[v].hv;
        for (int n = 0; n < OS; n++) begin
            bias[DW*n +: DW] = vt[v].ramp ? 16'(n*256) : 16'h0000;
            for (int k = 0; k < IN; k++)
                rew[DW*(IN*n+k) +: DW] = (n < 8) ? vt[v].w_lo : vt[v].w_hi;
        end
    endtask

    task automatic run_main(input int abort_at, input int pulse_at,
                            input int limit,
                            output int done_at, output int idle_at);
        int cyc;
        done_at = -1;
        idle_at = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (cyc <= limit && done_at < 0) begin
            if (done) done_at = cyc;
            if (!busy && idle_at < 0) idle_at = cyc;
            start = (cyc == pulse_at);
            abort = (cyc == abort_at);
            if (done_at < 0) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int da, ia, cyc;

        vt[0] = '{16'h1000, 16'h1000, 16'h1000, 1'b0,
                  64'sh1F000000, 64'sh1F000000};
        vt[1] = '{16'h7FFF, 16'h7FFF, 16'h8000, 1'b0,
                  64'sd4294967295, -64'sd4294967296};
        vt[2] = '{16'h0000, 16'h1000, 16'h1000, 1'b1,
                  64'sd0, 64'sd0};
        vt[3] = '{16'h1000, 16'hF000, 16'h0800, 1'b1,
                  -64'sd520093696, 64'sd260046848};
        vt[4] = '{16'hFFFF, 16'h7FFF, 16'h8000, 1'b0,
                  -64'sd1015777, 64'sd1015808};

        rst = 1'b0;
        start = 1'b0; abort = 1'b0;
        start5 = 1'b0; abort5 = 1'b0;
        hid = '0; rew = '0; bias = '0;
        rew5 = '0; bias5 = '0;

        #2;
        chk("reset_gate_out", 64'(|gate_out), 64'sd0);
        chk("reset_busy", 64'(busy), 64'sd0);
        chk("reset_done", 64'(done), 64'sd0);

        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        chk("start_abort_idle_busy", 64'(busy), 64'sd0);
        start = 1'b0;
        abort = 1'b0;

        for (int v = 0; v < 5; v++) begin
            set_main(v);
            run_main(0, 0, 400, da, ia);
            chk($sformatf("vec%0d_done_cycle", v), da, 265);
            chk($sformatf("vec%0d_busy_gap", v), ia, -1);
            chk($sformatf("vec%0d_busy_after", v), 64'(busy), 0);
            chk($sformatf("vec%0d_done_after", v), 64'(done), 0);
            for (int n = 0; n < OS; n++)
                chk($sformatf("vec%0d_slot%0d", v, n), slot(n),
                    exp_slot(v, n));
        end

        set_main(2);
        run_main(0, 0, 400, da, ia);
        set_main(0);
        run_main(40, 0, 60, da, ia);
        chk("abort_no_done", da, -1);
        chk("abort_idle_cycle", ia, 41);
        for (int n = 0; n < OS; n++)
            chk($sformatf("abort_slot%0d", n), slot(n),
                (n < 2) ? exp_slot(0, n) : exp_slot(2, n));

        run_main(0, 10, 400, da, ia);
        chk("restart_done_cycle", da, 265);
        chk("restart_busy_gap", ia, -1);
        for (int n = 0; n < OS; n++)
            chk($sformatf("restart_slot%0d", n), slot(n), exp_slot(0, n));

        for (int k = 0; k < IN; k++) hid[DW*k +: DW] = 16'h1000;
        for (int n = 0; n < O5; n++) begin
            bias5[DW*n +: DW] = 16'(n*256);
            for (int k = 0; k < IN; k++)
                rew5[DW*(IN*n+k) +: DW] = 16'h1000;
        end
        @(negedge clk);
        start5 = 1'b1;
        @(posedge clk);
        #1;
        start5 = 1'b0;
        cyc = 1;
        da = -1;
        ia = -1;
        while (cyc <= 200 && da < 0) begin
            if (done5) da = cyc;
            if (!busy5 && ia < 0) ia = cyc;
            if (da < 0) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        chk("partial_done_cycle", da, 100);
        chk("partial_busy_gap", ia, -1);
        for (int n = 0; n < O5; n++)
            chk($sformatf("partial_slot%0d", n), slot5(n),
                model_act(64'sh1F000000 + longint'(n) * 64'sd1048576));

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        chk("pre_reset_busy", 64'(busy), 64'sd1);
        rst = 1'b0;
        #1;
        chk("async_rst_gate_out", 64'(|gate_out), 64'sd0);
        chk("async_rst_gate5", 64'(|gate5), 64'sd0);
        chk("async_rst_busy", 64'(busy), 64'sd0);
        chk("async_rst_done", 64'(done), 64'sd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_busy", 64'(busy), 64'sd0);
        chk("post_reset_done", 64'(done), 64'sd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
